// File: rtl/fpa_adder.sv
// fpa_adder: IEEE-754 binary32 adder, round-to-nearest-even, one-cycle latency.
// The whole datapath is combinational from a/b to the single result register.
module fpa_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] s_d;
  logic [31:0] s_q;

  // operand classification
  logic        a_nan, b_nan, a_inf, b_inf;

  // ordered operands (big has the larger magnitude)
  logic        swap;
  logic [31:0] big;
  logic [30:0] sml;
  logic [7:0]  big_exp, sml_exp;
  logic [23:0] big_sig, sml_sig;
  logic [7:0]  diff;

  // alignment and significand add: 24 bits + guard/round/sticky
  logic [26:0] big_ext;
  logic [26:0] sml_ext;
  logic [53:0] wide;
  logic [26:0] sml_al;
  logic        eff_sub;
  logic [27:0] sum;

  // normalization and rounding
  logic [4:0]  lz;
  logic [9:0]  e_lim;
  logic [4:0]  sh;
  logic [26:0] m;
  logic [9:0]  e;
  logic        round_up;
  logic [24:0] mant;
  logic [9:0]  exp_f;
  logic [22:0] frac;

  // Leading-zero count over the 27-bit pre-normalization significand.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Full add datapath: unpack, swap, align, add, normalize, round, pack, specials.
  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Magnitude order equals the order of the 31-bit exponent|fraction field.
    swap = (b[30:0] > a[30:0]);
    big  = swap ? b : a;
    sml  = swap ? a[30:0] : b[30:0];

    // Subnormals use exponent 1 with a zero hidden bit.
    big_exp = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    sml_exp = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    big_sig = {(big[30:23] != 8'd0), big[22:0]};
    sml_sig = {(sml[30:23] != 8'd0), sml[22:0]};
    diff    = big_exp - sml_exp;

    big_ext = {big_sig, 3'b000};
    sml_ext = {sml_sig, 3'b000};
    wide    = 54'd0;
    if (diff >= 8'd27) begin
      // Everything falls below the sticky position.
      sml_al = {26'd0, |sml_sig};
    end else begin
      wide   = {sml_ext, 27'd0} >> diff;
      sml_al = wide[53:27] | {26'd0, |wide[26:0]};
    end

    eff_sub = a[31] ^ b[31];
    if (eff_sub) sum = {1'b0, big_ext} - {1'b0, sml_al};
    else         sum = {1'b0, big_ext} + {1'b0, sml_al};

    // Normalize: right by one on carry-out, else left by lzc clamped so the
    // exponent never goes below 1 (gradual underflow).
    lz    = lzc27(sum[26:0]);
    e_lim = {2'b00, big_exp} - 10'd1;
    sh    = 5'd0;
    if (sum[27]) begin
      m = sum[27:1] | {26'd0, sum[0]};
      e = {2'b00, big_exp} + 10'd1;
    end else begin
      if ({5'd0, lz} > e_lim) sh = e_lim[4:0];
      else                    sh = lz;
      m = sum[26:0] << sh;
      e = {2'b00, big_exp} - {5'd0, sh};
    end

    // Round to nearest, ties to even.
    round_up = m[2] & (m[1] | m[0] | m[3]);
    mant     = {1'b0, m[26:3]} + {24'd0, round_up};

    // A hidden bit of 0 after rounding means subnormal (e is 1 in that case).
    if (mant[24]) begin
      exp_f = e + 10'd1;
      frac  = mant[23:1];
    end else if (mant[23]) begin
      exp_f = e;
      frac  = mant[22:0];
    end else begin
      exp_f = 10'd0;
      frac  = mant[22:0];
    end

    if (exp_f >= 10'd255) s_d = {big[31], 8'hFF, 23'd0};
    else                  s_d = {big[31], exp_f[7:0], frac};

    // Special cases override the arithmetic result, highest priority first.
    if (a_nan || b_nan) begin
      s_d = QNAN;
    end else if (a_inf && b_inf) begin
      s_d = (a[31] != b[31]) ? QNAN : a;
    end else if (a_inf) begin
      s_d = a;
    end else if (b_inf) begin
      s_d = b;
    end else if (sum == 28'd0) begin
      // Exact cancellation is +0; zero plus zero keeps a shared sign.
      s_d = {(~eff_sub) & a[31] & b[31], 31'd0};
    end
  end

  // Result register, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 32'd0;
    else        s_q <= s_d;
  end

  assign s = s_q;

endmodule

// File: tb/tb_fpa_adder.sv
// tb_fpa_adder: directed vectors with hand-computed binary32 sums.
module tb_fpa_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s;

  int total;
  int bad;

  fpa_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("txn %-10s a=%08h b=%08h s=%08h exp=%08h", tag, a, b, obs, exp);
  endtask

  // Drive a pair between edges, then sample just after the capturing edge.
  task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp);
    @(negedge clk);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    check(tag, s, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a     = 32'h3F80_0000;
    b     = 32'h3F80_0000;
    rst_n = 1'b1;

    // Reset pulse between edges clears s immediately.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", s, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_hold", s, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_first", s, 32'h4000_0000);

    // Back-to-back pair, no bubble.
    apply("norm1", 32'h3FA0_0000, 32'h3F80_0000, 32'h4010_0000);
    apply("norm2", 32'h4049_0FD0, 32'h40A9_999A, 32'h4107_10C1);
    apply("sub1", 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000);

    // Subnormals.
    apply("dnrm_add", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
    apply("dnrm_up", 32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000);
    apply("dnrm_down", 32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF);

    // Cancellation and rounding.
    apply("cancel", 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
    apply("tie_even", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    apply("tie_odd", 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);

    // Overflow and specials.
    apply("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    apply("inf_minf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    apply("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    apply("minf_fin", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    apply("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);

    // Signed zeros.
    apply("mz_mz", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    apply("pz_mz", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    apply("x_mz", 32'hBF80_0000, 32'h8000_0000, 32'hBF80_0000);

    // Mid-stream reset discards the in-flight result.
    @(negedge clk);
    a = 32'h3FA0_0000;
    b = 32'h3F80_0000;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid", s, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel", s, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_after", s, 32'h4010_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
